// File: rtl/tlb_miss_walker.sv
// Two-level hardware page-table walker that refills a direct-mapped TLB on a miss.
//
// Pages are 1 KB: directory index = va[31:20], table index = va[19:10].
// A walk reads the page-directory entry at {ptBase[31:14], va[31:20], 2'b00}, then the
// page-table entry at {pde[31:12], va[19:10], 2'b00}. Bit 0 of each entry is its valid bit.
// On success the TLB write side is strobed for one cycle with the 22-bit physical page.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   missValid       level request to start a walk (sampled only when idle)
//   missVirtAddr    faulting virtual address, captured with missValid
//   ptBase          page-directory base, 16 KB aligned (low 14 bits ignored)
//   memReq/memAddr  read request and word address, held until memAck
//   memAck/memData  read completion and data
//   tlbWriteEnable  one-cycle TLB write strobe qualifying tlbVirtAddr/tlbPhysPage
//   busy            high whenever a walk is in progress
//   walkDone        one-cycle completion pulse; walkFault is valid with it
//                   (00 ok, 01 directory invalid, 10 table invalid, 11 timeout)
//
// MEM_TIMEOUT bounds the cycles memReq may wait for memAck; 0 disables the timeout.

module tlb_miss_walker #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        missValid,
    input  logic [31:0] missVirtAddr,
    input  logic [31:0] ptBase,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic        tlbWriteEnable,
    output logic [31:0] tlbVirtAddr,
    output logic [31:0] tlbPhysPage,
    output logic        busy,
    output logic        walkDone,
    output logic [1:0]  walkFault
);

    typedef enum logic [2:0] {StIdle, StL1, StL2, StFill, StFault} state_t;

    // The timeout fires on the edge that would bring the wait count up to MEM_TIMEOUT.
    localparam logic [31:0] LastWaitCnt = 32'(MEM_TIMEOUT) - 32'd1;

    state_t      state_q;
    logic [31:0] va_q;
    logic [31:0] wait_cnt_q;
    logic        timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt_q == LastWaitCnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            va_q           <= '0;
            wait_cnt_q     <= '0;
            memReq         <= 1'b0;
            memAddr        <= '0;
            tlbWriteEnable <= 1'b0;
            tlbVirtAddr    <= '0;
            tlbPhysPage    <= '0;
            busy           <= 1'b0;
            walkDone       <= 1'b0;
            walkFault      <= 2'b00;
        end else begin
            // Strobes default low; they are raised only on entry to FILL/FAULT.
            tlbWriteEnable <= 1'b0;
            walkDone       <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (missValid) begin
                        va_q       <= missVirtAddr;
                        memReq     <= 1'b1;
                        memAddr    <= {ptBase[31:14], missVirtAddr[31:20], 2'b00};
                        wait_cnt_q <= '0;
                        busy       <= 1'b1;
                        state_q    <= StL1;
                    end
                end

                StL1, StL2: begin
                    // A response in the timeout cycle wins over the timeout.
                    if (memAck) begin
                        wait_cnt_q <= '0;
                        if (!memData[0]) begin
                            memReq    <= 1'b0;
                            walkDone  <= 1'b1;
                            walkFault <= (state_q == StL1) ? 2'b01 : 2'b10;
                            state_q   <= StFault;
                        end else if (state_q == StL1) begin
                            // memReq stays high; only the address moves to the table entry.
                            memAddr <= {memData[31:12], va_q[19:10], 2'b00};
                            state_q <= StL2;
                        end else begin
                            memReq         <= 1'b0;
                            tlbWriteEnable <= 1'b1;
                            tlbVirtAddr    <= va_q;
                            tlbPhysPage    <= {10'b0, memData[31:10]};
                            walkDone       <= 1'b1;
                            walkFault      <= 2'b00;
                            state_q        <= StFill;
                        end
                    end else if (timeout_hit) begin
                        memReq    <= 1'b0;
                        walkDone  <= 1'b1;
                        walkFault <= 2'b11;
                        state_q   <= StFault;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end

                StFill, StFault: begin
                    busy      <= 1'b0;
                    walkFault <= 2'b00;
                    state_q   <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_miss_walker.sv
// Self-checking bench for tlb_miss_walker. Expected read addresses and walk results are
// pushed to scoreboard queues as each walk is launched; a monitor pops and compares them
// when the DUT acknowledges a read or pulses walkDone.

module tb_tlb_miss_walker;

    localparam int unsigned TIMEOUT = 4;
    localparam logic [31:0] VA = 32'h1234_5678;
    localparam logic [31:0] PB = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        missValid = 1'b0;
    logic [31:0] missVirtAddr = '0;
    logic [31:0] ptBase = '0;
    logic        memAck = 1'b0;
    logic [31:0] memData = '0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        tlbWriteEnable;
    logic [31:0] tlbVirtAddr;
    logic [31:0] tlbPhysPage;
    logic        busy;
    logic        walkDone;
    logic [1:0]  walkFault;

    tlb_miss_walker #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset          (reset),
        .missValid      (missValid),
        .missVirtAddr   (missVirtAddr),
        .ptBase         (ptBase),
        .memReq         (memReq),
        .memAddr        (memAddr),
        .memAck         (memAck),
        .memData        (memData),
        .tlbWriteEnable (tlbWriteEnable),
        .tlbVirtAddr    (tlbVirtAddr),
        .tlbPhysPage    (tlbPhysPage),
        .busy           (busy),
        .walkDone       (walkDone),
        .walkFault      (walkFault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] va;
        logic [31:0] pp;
        logic [1:0]  fault;
    } done_t;

    logic [31:0] exp_addr_q[$];
    done_t       exp_done_q[$];
    logic [31:0] mon_addr;
    done_t       mon_done;

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (memReq && memAck) begin
                n_checks++;
                if (exp_addr_q.size() == 0) begin
                    $display("FAIL read_addr: unexpected read at %h, none expected", memAddr);
                end else begin
                    mon_addr = exp_addr_q.pop_front();
                    if (memAddr !== mon_addr)
                        $display("FAIL read_addr: got %h expected %h", memAddr, mon_addr);
                    else
                        n_pass++;
                end
            end
            if (walkDone) begin
                n_checks++;
                if (exp_done_q.size() == 0) begin
                    $display("FAIL walk_done: unexpected done fault=%b we=%b",
                             walkFault, tlbWriteEnable);
                end else begin
                    mon_done = exp_done_q.pop_front();
                    if (tlbWriteEnable !== mon_done.we || walkFault !== mon_done.fault ||
                        (mon_done.we && (tlbVirtAddr !== mon_done.va ||
                                         tlbPhysPage !== mon_done.pp)))
                        $display("FAIL walk_done: got we=%b fault=%b va=%h pp=%h expected we=%b fault=%b va=%h pp=%h",
                                 tlbWriteEnable, walkFault, tlbVirtAddr, tlbPhysPage,
                                 mon_done.we, mon_done.fault, mon_done.va, mon_done.pp);
                    else
                        n_pass++;
                end
            end
            if (tlbWriteEnable && !walkDone) begin
                n_checks++;
                $display("FAIL tlb_write: write strobe without walkDone");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: waits for memReq, holds off memAck for dly cycles, then acks once.
    task automatic serve(input logic [31:0] data, input int dly);
        int t;
        logic [31:0] a0;
        t = 0;
        while (memReq !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        n_checks++;
        if (memReq !== 1'b1) begin
            $display("FAIL serve_req: memReq=%b expected 1", memReq);
            return;
        end
        n_pass++;
        a0 = memAddr;
        for (int i = 0; i < dly; i++) begin
            step();
            n_checks++;
            if (memReq !== 1'b1 || memAddr !== a0)
                $display("FAIL addr_stable: memReq=%b memAddr=%h expected 1 %h",
                         memReq, memAddr, a0);
            else
                n_pass++;
        end
        memAck = 1'b1;
        memData = data;
        step();
        memAck = 1'b0;
        memData = '0;
    endtask

    task automatic run_walk(input logic [31:0] va, input logic [31:0] pb,
                            input logic [31:0] pde, input logic [31:0] pte,
                            input int d1, input int d2, input bit hold);
        done_t d;
        int c0, t, exp_lat;
        exp_addr_q.push_back({pb[31:14], va[31:20], 2'b00});
        if (pde[0]) exp_addr_q.push_back({pde[31:12], va[19:10], 2'b00});
        d.we = pde[0] & pte[0];
        d.va = va;
        d.pp = {10'b0, pte[31:10]};
        d.fault = !pde[0] ? 2'b01 : (!pte[0] ? 2'b10 : 2'b00);
        exp_done_q.push_back(d);
        exp_lat = pde[0] ? 3 + d1 + d2 : 2 + d1;

        missValid = 1'b1;
        missVirtAddr = va;
        ptBase = pb;
        c0 = cyc;
        serve(pde, d1);
        if (pde[0]) serve(pte, d2);
        t = 0;
        while (walkDone !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        n_checks++;
        if (walkDone !== 1'b1 || cyc - c0 != exp_lat)
            $display("FAIL walk_latency: walkDone=%b after %0d cycles expected 1 after %0d",
                     walkDone, cyc - c0, exp_lat);
        else
            n_pass++;
        n_checks++;
        if (memReq !== 1'b0 || busy !== 1'b1)
            $display("FAIL done_state: memReq=%b busy=%b expected 0 1", memReq, busy);
        else
            n_pass++;
        if (!hold) missValid = 1'b0;
        step();
        n_checks++;
        if (walkDone !== 1'b0 || tlbWriteEnable !== 1'b0 || busy !== 1'b0)
            $display("FAIL done_pulse: walkDone=%b we=%b busy=%b expected 0 0 0",
                     walkDone, tlbWriteEnable, busy);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({memReq, memAddr, tlbWriteEnable, tlbVirtAddr, tlbPhysPage, busy, walkDone,
             walkFault} !== '0)
            $display("FAIL reset_values: got %h expected 0",
                     {memReq, memAddr, tlbWriteEnable, tlbVirtAddr, tlbPhysPage, busy,
                      walkDone, walkFault});
        else
            n_pass++;
        reset = 1'b0;
        memAck = 1'b1;
        memData = 32'hFFFF_FFFF;
        step();
        memAck = 1'b0;
        memData = '0;
        step();
        n_checks++;
        if (memReq !== 1'b0 || busy !== 1'b0 || walkDone !== 1'b0 || tlbWriteEnable !== 1'b0)
            $display("FAIL idle_ack_ignored: memReq=%b busy=%b done=%b we=%b expected 0 0 0 0",
                     memReq, busy, walkDone, tlbWriteEnable);
        else
            n_pass++;
    endtask

    task automatic test_success();
        // Known-answer: 0x0001_048C then 0x0020_0454, page 0x2AF3.
        n_checks++;
        if ({PB[31:14], VA[31:20], 2'b00} !== 32'h0001_048C)
            $display("FAIL model_l1: got %h expected 0001048c", {PB[31:14], VA[31:20], 2'b00});
        else
            n_pass++;
        run_walk(VA, PB, 32'h0020_0001, 32'h00AB_CC01, 0, 0, 1'b0);
        n_checks++;
        if (tlbVirtAddr !== VA || tlbPhysPage !== 32'h0000_2AF3)
            $display("FAIL tlb_hold: va=%h pp=%h expected %h 00002af3",
                     tlbVirtAddr, tlbPhysPage, VA);
        else
            n_pass++;
    endtask

    task automatic test_dir_fault();
        run_walk(VA, PB, 32'h0020_0000, 32'h00AB_CC01, 0, 0, 1'b0);
    endtask

    task automatic test_table_fault();
        run_walk(VA, PB, 32'h0020_0001, 32'h00AB_CC00, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        done_t d;
        int n, t;
        d = '0;
        d.fault = 2'b11;
        exp_done_q.push_back(d);
        missValid = 1'b1;
        missVirtAddr = VA;
        ptBase = PB;
        t = 0;
        while (memReq !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        n_checks++;
        if (memAddr !== 32'h0001_048C)
            $display("FAIL timeout_addr: got %h expected 0001048c", memAddr);
        else
            n_pass++;
        n = 0;
        while (memReq === 1'b1 && n < 30) begin
            n++;
            step();
        end
        n_checks++;
        if (n != 4 || walkDone !== 1'b1)
            $display("FAIL timeout_len: memReq high %0d cycles done=%b expected 4 1", n, walkDone);
        else
            n_pass++;
        missValid = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL timeout_busy: busy=%b expected 0", busy);
        else
            n_pass++;
    endtask

    task automatic test_delayed();
        // Three idle wait cycles reach the timeout count; the ack in that cycle must win.
        run_walk(VA, PB, 32'h0020_0001, 32'h00AB_CC01, 3, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_walk(VA, PB, 32'h0020_0001, 32'h00AB_CC01, 0, 0, 1'b1);
        run_walk(VA, PB, 32'h0020_0001, 32'h1357_9BDF, 0, 1, 1'b0);
    endtask

    task automatic test_reset_mid_walk();
        exp_addr_q.push_back({PB[31:14], VA[31:20], 2'b00});
        missValid = 1'b1;
        missVirtAddr = VA;
        ptBase = PB;
        serve(32'h0020_0001, 0);
        n_checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h0020_0454)
            $display("FAIL l2_req: memReq=%b memAddr=%h expected 1 00200454", memReq, memAddr);
        else
            n_pass++;
        reset = 1'b1;
        missValid = 1'b0;
        step();
        reset = 1'b0;
        memAck = 1'b1;
        memData = 32'h00AB_CC01;
        n_checks++;
        if (memReq !== 1'b0 || busy !== 1'b0 || walkDone !== 1'b0 || tlbWriteEnable !== 1'b0)
            $display("FAIL mid_reset: memReq=%b busy=%b done=%b we=%b expected 0 0 0 0",
                     memReq, busy, walkDone, tlbWriteEnable);
        else
            n_pass++;
        step();
        memAck = 1'b0;
        memData = '0;
        n_checks++;
        if (memReq !== 1'b0 || busy !== 1'b0 || walkDone !== 1'b0 || tlbWriteEnable !== 1'b0)
            $display("FAIL stray_ack: memReq=%b busy=%b done=%b we=%b expected 0 0 0 0",
                     memReq, busy, walkDone, tlbWriteEnable);
        else
            n_pass++;
        run_walk(32'hCAFE_0C00, PB, 32'h0040_0001, 32'hFFFF_FC01, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] va, pb, pde, pte;
        for (int i = 0; i < 8; i++) begin
            va = $urandom;
            pb = $urandom;
            pde = $urandom;
            pte = $urandom;
            pde[0] = (i % 4) != 1;
            pte[0] = (i % 4) != 2;
            run_walk(va, pb, pde, pte, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                     1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_success();
        test_dir_fault();
        test_table_fault();
        test_timeout();
        test_delayed();
        test_back_to_back();
        test_reset_mid_walk();
        test_random();
        repeat (2) step();
        n_checks++;
        if (exp_addr_q.size() != 0 || exp_done_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d reads %0d walks left expected 0 0",
                     exp_addr_q.size(), exp_done_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
